// File: rtl/pea_pkg.sv
// Shared PE-array definitions: data width, output FIFO depth and output stream type.
package pea_pkg;

   localparam int N_BITS         = 32;
   localparam int OUT_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [N_BITS-1:0] data;
      logic              valid;
   } out_stream_t;

endpackage

// File: rtl/pea_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear.
// Full/empty come from the occupancy count; pointers wrap naturally.
module pea_sync_fifo
   import pea_pkg::*;
#(
   parameter int    WIDTH = N_BITS,
   parameter int    DEPTH = OUT_FIFO_DEPTH,
   localparam int   CNT_W = $clog2(DEPTH) + 1,
   localparam int   PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] count_next_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   // Guards keep the storage consistent even if a caller misbehaves.
   assign push_ok = push_i && (count_q != DEPTH_C);
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o      = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign count_next_o = count_d;
   assign full_o       = (count_q == DEPTH_C);
   assign empty_o      = (count_q == '0);

endmodule

// File: rtl/pe_out_collector.sv
// Collects one PE output into a FIFO, back-pressures the array and re-exports a ready/valid stream.
// Optional stall counter enabled by PE_OUT_COLLECTOR_PERF_EN.
module pe_out_collector
   import pea_pkg::*;
#(
   parameter int  DEPTH = OUT_FIFO_DEPTH,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic [N_BITS-1:0] pe_res_i,
   input  logic              pe_valid_i,
   output logic              pea_ready_o,
   output logic [N_BITS-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [31:0]       stall_cycles_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   out_stream_t      stream;
   logic             push, pop;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] count_next;
   logic             pea_ready_q, pea_ready_d;

   assign push = pe_valid_i && pea_ready_q;
   assign pop  = stream.valid && ready_i;

   pea_sync_fifo #(
      .WIDTH (N_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .push_i       (push),
      .pop_i        (pop),
      .wdata_i      (pe_res_i),
      .rdata_o      (stream.data),
      .count_o      (count_o),
      .count_next_o (count_next),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   assign stream.valid = !fifo_empty;

   // count_next is already zero on clear, so ready returns to 1 with it.
   always_comb begin
      pea_ready_d = (count_next < DEPTH_C);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pea_ready_q <= 1'b1;
      end else begin
         pea_ready_q <= pea_ready_d;
      end
   end

   assign pea_ready_o = pea_ready_q;
   assign data_o      = stream.data;
   assign valid_o     = stream.valid;

`ifdef PE_OUT_COLLECTOR_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (clear_i) begin
         stall_d = '0;
      end else if (pe_valid_i && !pea_ready_q && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
`endif

endmodule
